// File: rtl/barrel_rotate_left_pipe.sv
// barrel_rotate_left_pipe
//   Pipelined barrel rotator. Rotates a WIDTH-bit word left by samt positions.
//   Each registered stage resolves one samt bit, MSB first (16, 8, 4, 2, 1 by default).
//   A single global advance signal moves the whole pipe; bubbles are not collapsed.
//   Requires 2**SAMT_W <= WIDTH.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears valids, data and samt registers
//   flush      synchronous; clears all valid bits, data registers keep their contents
//   in_valid   D_in/samt valid this cycle
//   in_ready   pipe can accept (depends only on out_valid/out_ready)
//   D_in       word to rotate
//   samt       left-rotate amount
//   out_valid  D_out holds a result
//   out_ready  consumer accepts the result
//   D_out      rotated word, straight from the last stage register
//   busy       OR of all stage valid bits

module barrel_rotate_left_pipe #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned SAMT_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  D_in,
   input  logic [SAMT_W-1:0] samt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  D_out,
   output logic              busy
);

   logic                adv;
   logic [SAMT_W-1:0]   stage_valid;
   logic [WIDTH-1:0]    stage_data [SAMT_W];
   // Remaining (not yet applied) samt bits of each stage, zero-extended.
   logic [SAMT_W-1:0]   stage_rem  [SAMT_W];

   // The last stage is the output register, so the pipe moves whenever it is
   // empty or being drained.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < SAMT_W; k++) begin : g_stage
      localparam int unsigned N  = 2 ** (SAMT_W - 1 - k);
      // Amount bits still carried into this stage; the MSB is applied here.
      localparam int unsigned AW = SAMT_W - k;

      logic [WIDTH-1:0] src;
      logic [AW-1:0]    amt;
      logic             src_valid;
      logic [WIDTH-1:0] rot;
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      if (k == 0) begin : g_head
         assign src       = D_in;
         assign amt       = samt;
         assign src_valid = in_valid;
      end else begin : g_tail
         assign src       = stage_data[k-1];
         assign amt       = stage_rem[k-1][AW-1:0];
         assign src_valid = stage_valid[k-1];
      end

      assign rot = amt[AW-1] ? {src[WIDTH-1-N:0], src[WIDTH-1 -: N]} : src;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else if (flush) begin
            valid_q <= 1'b0;
         end else if (adv) begin
            data_q  <= rot;
            valid_q <= src_valid;
         end
      end

      assign stage_data[k]  = data_q;
      assign stage_valid[k] = valid_q;

      if (k < SAMT_W - 1) begin : g_rem
         logic [AW-2:0] rem_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rem_q <= '0;
            end else if (!flush && adv) begin
               rem_q <= amt[AW-2:0];
            end
         end

         assign stage_rem[k] = SAMT_W'(rem_q);
      end else begin : g_last
         // Nothing left to apply after the final stage.
         assign stage_rem[k] = '0;
      end
   end

   assign out_valid = stage_valid[SAMT_W-1];
   assign D_out     = stage_data[SAMT_W-1];
   assign busy      = |stage_valid;

endmodule

// File: tb/tb_barrel_rotate_left_pipe.sv
// tb_barrel_rotate_left_pipe
//   Directed tests with hand-computed values plus a scoreboard that predicts every
//   accepted word with an independent rotate model and checks FIFO order at the output.

module tb_barrel_rotate_left_pipe;

   localparam int unsigned WIDTH  = 64;
   localparam int unsigned SAMT_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  D_in;
   logic [SAMT_W-1:0] samt;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  D_out;
   logic              busy;

   barrel_rotate_left_pipe #(
      .WIDTH  (WIDTH),
      .SAMT_W (SAMT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .D_in      (D_in),
      .samt      (samt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D_out     (D_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rotl(input logic [63:0] x, input int s);
      logic [127:0] t;
      t = {x, x} << s;
      return t[127:64];
   endfunction

   function automatic logic [63:0] ror(input logic [63:0] x, input int s);
      logic [127:0] t;
      t = {x, x} >> s;
      return t[63:0];
   endfunction

   typedef struct {
      logic [63:0] x;
      int          s;
   } item_t;

   item_t       exp_q [$];
   logic [63:0] out_log [$];
   int          run     = 0;
   int          max_run = 0;

   // Scoreboard: consume outputs, then record this cycle's accepted input.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            out_log.push_back(D_out);
            run++;
            if (run > max_run) max_run = run;
            check("out_has_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               item_t it;
               it = exp_q.pop_front();
               check("rotl", D_out, rotl(it.x, it.s));
               check("ror_inverse", ror(D_out, it.s), it.x);
            end
         end else begin
            run = 0;
         end
         if (flush) begin
            exp_q.delete();
         end else if (in_valid && in_ready) begin
            exp_q.push_back('{x: D_in, s: int'(samt)});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word, count edges until out_valid is seen.
   task automatic send_one(input logic [63:0] x, input logic [SAMT_W-1:0] s, output int lat);
      in_valid = 1'b1;
      D_in     = x;
      samt     = s;
      lat      = 0;
      do begin
         step();
         lat++;
         in_valid = 1'b0;
      end while (!out_valid && lat < 20);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || busy) && g < 60) begin
         step();
         g++;
      end
      check("drain_timeout", 64'(g < 60), 64'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [63:0] stall_x [7];
   int          stall_s [7];
   int          lat;
   int          acc_cnt;
   logic        acc;
   int          guard;

   initial begin
      stall_x = '{64'hF, 64'h1111_2222_3333_4444, 64'hFFFF_0000_FFFF_0000, 64'h5,
                  64'h8000_0000_0000_0001, 64'hCAFE_F00D_1234_5678, 64'h0F0F_0F0F_0F0F_0F0F};
      stall_s = '{4, 7, 13, 0, 31, 2, 20};

      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      D_in      = '0;
      samt      = '0;

      // Reset state
      #3;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_D_out", D_out, 64'h0);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      step();
      rst       = 1'b0;
      out_ready = 1'b1;
      step();

      // Single words: latency and hand-computed results
      send_one(64'h1, 5'd1, lat);
      check("lat_rotl1", 64'(lat), 64'(5));
      check("rotl1", D_out, 64'h2);
      step();
      send_one(64'h8000_0000_0000_0000, 5'd1, lat);
      check("wrap_msb", D_out, 64'h1);
      step();
      send_one(64'h1, 5'd31, lat);
      check("rotl31", D_out, 64'h0000_0000_8000_0000);
      step();
      drain();

      // Back-to-back stream, samt 0..7
      out_log.delete();
      max_run = 0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         D_in     = 64'h0123_4567_89AB_CDEF;
         samt     = SAMT_W'(i);
         step();
      end
      in_valid = 1'b0;
      drain();
      check("stream_count", 64'(out_log.size()), 64'(8));
      check("stream_run", 64'(max_run), 64'(8));
      if (out_log.size() == 8) begin
         check("stream_samt0", out_log[0], 64'h0123_4567_89AB_CDEF);
         check("stream_samt1", out_log[1], 64'h0246_8ACF_1357_9BDE);
         check("stream_samt4", out_log[4], 64'h1234_5678_9ABC_DEF0);
      end

      // Backpressure: out_ready low while offering 7 words
      out_log.delete();
      out_ready = 1'b0;
      acc_cnt   = 0;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         D_in     = stall_x[acc_cnt];
         samt     = SAMT_W'(stall_s[acc_cnt]);
         #1;
         acc = in_ready;
         step();
         if (acc) acc_cnt++;
      end
      check("stall_accepted", 64'(acc_cnt), 64'(5));
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_out_valid", 64'(out_valid), 64'(1));
      check("stall_D_out_hold", D_out, 64'hF0);
      out_ready = 1'b1;
      guard     = 0;
      while (acc_cnt < 7 && guard < 30) begin
         in_valid = 1'b1;
         D_in     = stall_x[acc_cnt];
         samt     = SAMT_W'(stall_s[acc_cnt]);
         #1;
         acc = in_ready;
         step();
         if (acc) acc_cnt++;
         guard++;
      end
      in_valid = 1'b0;
      drain();
      check("stall_drained", 64'(out_log.size()), 64'(7));
      if (out_log.size() != 0) check("stall_first", out_log[0], 64'hF0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         D_in     = 64'(i + 1);
         samt     = SAMT_W'(i);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      check("amid_out_valid", 64'(out_valid), 64'(0));
      check("amid_D_out", D_out, 64'h0);
      check("amid_busy", 64'(busy), 64'(0));
      check("amid_in_ready", 64'(in_ready), 64'(1));
      exp_q.delete();
      step();
      step();
      rst = 1'b0;
      out_log.delete();
      repeat (10) step();
      check("post_rst_no_out", 64'(out_log.size()), 64'(0));
      check("post_rst_busy", 64'(busy), 64'(0));

      // Flush with 4 words in flight and a new word offered
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         D_in     = 64'hA000 + 64'(i);
         samt     = SAMT_W'(i + 3);
         step();
      end
      D_in  = 64'hDEAD_BEEF_0000_0000;
      samt  = 5'd9;
      flush = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_busy", 64'(busy), 64'(0));
      check("flush_in_ready", 64'(in_ready), 64'(1));
      out_log.delete();
      send_one(64'hF0, 5'd4, lat);
      check("flush_lat", 64'(lat), 64'(5));
      check("flush_next", D_out, 64'hF00);
      step();
      check("flush_only_new", 64'(out_log.size()), 64'(1));
      drain();

      // Random regression with random backpressure
      for (int n = 0; n < 10000; n++) begin
         in_valid  = 1'b1;
         D_in      = {$urandom(), $urandom()};
         samt      = SAMT_W'($urandom_range(0, 31));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
